// File: rtl/fifo_rd_stream.sv
// Read-side consumer of the async FIFO: pops words and re-presents them as a valid/ready
// stream through a 2-entry skid buffer, with drain control and a delivered-word counter.
module fifo_rd_stream #(
    parameter int DATA_SIZE = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 rd_clk,
    input  logic                 rd_rstn,
    input  logic                 enable,
    input  logic                 fifo_rempty,
    input  logic [DATA_SIZE-1:0] fifo_rd_data,
    output logic                 fifo_rd_en,
    // Stream handshake: a word moves on every rising edge where m_valid && m_ready;
    // while m_valid && !m_ready, m_valid and m_data hold until accepted.
    output logic                 m_valid,
    output logic [DATA_SIZE-1:0] m_data,
    input  logic                 m_ready,
    output logic                 idle,
    output logic [CNT_WIDTH-1:0] word_count,
    // Debug view of the FSM: 0 = IDLE, 1 = RUN, 2 = DRAIN
    output logic [1:0]           state_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [1:0]             occ_q, occ_d;
    logic                   inflight_q;
    logic [DATA_SIZE-1:0]   buf0_q, buf0_d;
    logic [DATA_SIZE-1:0]   buf1_q, buf1_d;
    logic [CNT_WIDTH-1:0]   word_count_q, word_count_d;

    logic                   pop;
    logic                   credit;
    logic                   fetch_ok;
    logic                   pipe_empty;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge rd_clk or negedge rd_rstn) begin
        if (!rd_rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state. DRAIN only retires once nothing is buffered or in flight.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (enable) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!enable) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (enable) begin
                    state_d = ST_RUN;
                end else if (pipe_empty) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        idle     = (state_q == ST_IDLE);
        fetch_ok = (state_q == ST_RUN);
        state_o  = state_q;
    end

    // ------------------------------------------------------------------
    // Fetch control
    // ------------------------------------------------------------------
    assign pop        = m_valid && m_ready;
    assign pipe_empty = (occ_q == 2'd0) && !inflight_q;

    // A slot is free when fewer than two words are buffered or in flight, or one leaves now.
    always_comb begin
        credit = pop;
        if (occ_q == 2'd0) credit = 1'b1;
        if ((occ_q == 2'd1) && !inflight_q) credit = 1'b1;
    end

    assign fifo_rd_en = rd_rstn && fetch_ok && !fifo_rempty && credit;

    always_ff @(posedge rd_clk or negedge rd_rstn) begin
        if (!rd_rstn) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= fifo_rd_en;
        end
    end

    // ------------------------------------------------------------------
    // Output buffer: buf0 is the head, buf1 the second entry
    // ------------------------------------------------------------------
    always_comb begin
        occ_d  = occ_q;
        buf0_d = buf0_q;
        buf1_d = buf1_q;
        case ({inflight_q, pop})
            2'b10: begin
                if (occ_q == 2'd0) begin
                    buf0_d = fifo_rd_data;
                end else begin
                    buf1_d = fifo_rd_data;
                end
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                buf0_d = buf1_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                // Head leaves while a new word lands; occupancy is unchanged.
                if (occ_q == 2'd2) begin
                    buf0_d = buf1_q;
                    buf1_d = fifo_rd_data;
                end else begin
                    buf0_d = fifo_rd_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge rd_clk or negedge rd_rstn) begin
        if (!rd_rstn) begin
            occ_q  <= 2'd0;
            buf0_q <= '0;
            buf1_q <= '0;
        end else begin
            occ_q  <= occ_d;
            buf0_q <= buf0_d;
            buf1_q <= buf1_d;
        end
    end

    assign m_valid = (occ_q != 2'd0);
    assign m_data  = buf0_q;

    // ------------------------------------------------------------------
    // Delivered-word counter (wraps)
    // ------------------------------------------------------------------
    always_comb begin
        word_count_d = word_count_q;
        if (pop) word_count_d = word_count_q + CNT_WIDTH'(1);
    end

    always_ff @(posedge rd_clk or negedge rd_rstn) begin
        if (!rd_rstn) begin
            word_count_q <= '0;
        end else begin
            word_count_q <= word_count_d;
        end
    end

    assign word_count = word_count_q;

    // ------------------------------------------------------------------
    // Structural invariants
    // ------------------------------------------------------------------
    a_occ_bound: assert property (@(posedge rd_clk) disable iff (!rd_rstn)
        ({1'b0, occ_q} + {2'b00, inflight_q}) <= 3'd2);

    a_no_pop_empty: assert property (@(posedge rd_clk) disable iff (!rd_rstn)
        !(fifo_rd_en && fifo_rempty));

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: a queue-based FIFO model feeds two DUT instances (16- and 4-bit
// counters); a latency-aware scoreboard checks every cycle and directed tests pin literals.
module tb_fifo_rd_stream;

    localparam logic [1:0] M_IDLE  = 2'd0;
    localparam logic [1:0] M_RUN   = 2'd1;
    localparam logic [1:0] M_DRAIN = 2'd2;

    logic        rd_clk = 1'b0;
    logic        rd_rstn = 1'b0;
    logic        enable = 1'b0;
    logic        m_ready = 1'b0;
    logic        fifo_rempty;
    logic [7:0]  fifo_rd_data = '0;

    logic        fifo_rd_en, m_valid, idle;
    logic [7:0]  m_data;
    logic [15:0] word_count;
    logic [1:0]  state_dbg;

    logic        rd_en4, mv4, idle4;
    logic [7:0]  md4;
    logic [3:0]  wc4;
    logic [1:0]  state4;

    fifo_rd_stream #(.DATA_SIZE(8), .CNT_WIDTH(16)) dut (
        .rd_clk(rd_clk), .rd_rstn(rd_rstn), .enable(enable),
        .fifo_rempty(fifo_rempty), .fifo_rd_data(fifo_rd_data), .fifo_rd_en(fifo_rd_en),
        .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
        .idle(idle), .word_count(word_count), .state_o(state_dbg)
    );

    fifo_rd_stream #(.DATA_SIZE(8), .CNT_WIDTH(4)) dut4 (
        .rd_clk(rd_clk), .rd_rstn(rd_rstn), .enable(enable),
        .fifo_rempty(fifo_rempty), .fifo_rd_data(fifo_rd_data), .fifo_rd_en(rd_en4),
        .m_valid(mv4), .m_data(md4), .m_ready(m_ready),
        .idle(idle4), .word_count(wc4), .state_o(state4)
    );

    // ---------------- clock / watchdog ----------------
    always #5 rd_clk = ~rd_clk;

    int n_cmp = 0;
    int n_bad = 0;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    // ---------------- FIFO model + scoreboard ----------------
    logic [7:0]  fifo_q[$];
    int          fifo_level = 0;
    assign fifo_rempty = (fifo_level == 0);

    logic [7:0]  exp_q[$];        // words that left the FIFO and are owed downstream
    int          exp_edge_q[$];   // edge index at which each owed word was popped
    logic [7:0]  got_q[$];        // words the DUT actually delivered
    int          edge_cnt = 0;
    int          deliv_cnt = 0;
    logic [1:0]  mode = M_IDLE;

    function automatic void model_clear();
        exp_q.delete();
        exp_edge_q.delete();
        mode = M_IDLE;
        deliv_cnt = 0;
    endfunction

    // A popped word is visible one full edge after the edge that popped it.
    function automatic logic exp_valid();
        return (exp_q.size() > 0) && (exp_edge_q[0] < edge_cnt);
    endfunction

    always @(posedge rd_clk) begin
        logic       ev;
        int         outst;
        logic [7:0] w;
        if (!rd_rstn) begin
            model_clear();
        end else begin
            ev    = exp_valid();
            outst = exp_q.size();
            case (mode)
                M_IDLE:  if (enable) mode = M_RUN;
                M_RUN:   if (!enable) mode = M_DRAIN;
                default: begin
                    if (enable) mode = M_RUN;
                    else if (outst == 0) mode = M_IDLE;
                end
            endcase
            if (m_valid && m_ready) got_q.push_back(m_data);
            if (ev && m_ready) begin
                void'(exp_q.pop_front());
                void'(exp_edge_q.pop_front());
                deliv_cnt++;
            end
            edge_cnt++;
            if (fifo_rd_en && fifo_q.size() > 0) begin
                w = fifo_q.pop_front();
                fifo_rd_data <= w;
                exp_q.push_back(w);
                exp_edge_q.push_back(edge_cnt);
            end
        end
        fifo_level <= fifo_q.size();
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare, mid-cycle so all outputs have settled.
    always @(negedge rd_clk) begin
        logic ev, erd;
        if (rd_rstn) begin
            ev  = exp_valid();
            erd = (mode == M_RUN) && !fifo_rempty && ((exp_q.size() < 2) || (ev && m_ready));
            chk("m_valid", 32'(m_valid), 32'(ev));
            chk("m_valid_w4", 32'(mv4), 32'(ev));
            if (ev) begin
                chk("m_data", 32'(m_data), 32'(exp_q[0]));
                chk("m_data_w4", 32'(md4), 32'(exp_q[0]));
            end
            chk("fifo_rd_en", 32'(fifo_rd_en), 32'(erd));
            chk("fifo_rd_en_w4", 32'(rd_en4), 32'(erd));
            chk("idle", 32'(idle), 32'(mode == M_IDLE));
            chk("idle_w4", 32'(idle4), 32'(mode == M_IDLE));
            chk("state", 32'(state_dbg), 32'(mode));
            chk("word_count", 32'(word_count), 32'(deliv_cnt[15:0]));
            chk("word_count_w4", 32'(wc4), 32'(deliv_cnt[3:0]));
        end else begin
            chk("rd_en_in_reset", 32'(fifo_rd_en), 32'd0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge rd_clk);
        #1;
    endtask

    task automatic push_words(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) fifo_q.push_back(8'(int'(base) + i));
        fifo_level = fifo_q.size();
    endtask

    task automatic do_reset();
        enable  = 1'b0;
        m_ready = 1'b0;
        rd_rstn = 1'b0;
        model_clear();
        fifo_q.delete();
        fifo_level = 0;
        repeat (2) step();
        rd_rstn = 1'b1;
        step();
        got_q.delete();
    endtask

    task automatic wait_delivered(input string name, input int n, input int budget);
        for (int i = 0; i < budget && got_q.size() < n; i++) step();
        chk(name, 32'(got_q.size()), 32'(n));
    endtask

    task automatic check_seq(input string name, input logic [7:0] base, input int n);
        for (int i = 0; i < n && i < got_q.size(); i++)
            chk(name, 32'(got_q[i]), 32'(8'(int'(base) + i)));
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int pulses;
        int k;

        // Reset values while held in reset
        #2;
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'd0);
        chk("rst_word_count", 32'(word_count), 32'd0);
        chk("rst_idle", 32'(idle), 32'd1);

        // 1: continuous streaming, one word per cycle two edges after first rd_en
        do_reset();
        push_words(8'h10, 8);
        m_ready = 1'b1;
        enable  = 1'b1;
        for (k = 0; k < 10; k++) begin
            @(negedge rd_clk);
            if (fifo_rd_en) break;
        end
        chk("t1_first_rd_en", 32'(fifo_rd_en), 32'd1);
        @(posedge rd_clk);
        @(posedge rd_clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge rd_clk);
            chk("t1_valid", 32'(m_valid), 32'd1);
            chk("t1_data", 32'(m_data), 32'(8'h10 + i));
        end
        @(negedge rd_clk);
        chk("t1_word_count", 32'(word_count), 32'd8);
        chk("t1_valid_after", 32'(m_valid), 32'd0);

        // 2: sink stalled, fetch stops at two words
        do_reset();
        push_words(8'h10, 8);
        enable = 1'b1;
        pulses = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge rd_clk);
            if (fifo_rd_en) pulses++;
        end
        chk("t2_rd_pulses", 32'(pulses), 32'd2);
        chk("t2_valid_held", 32'(m_valid), 32'd1);
        chk("t2_data_held", 32'(m_data), 32'h10);
        step();
        m_ready = 1'b1;
        wait_delivered("t2_count", 8, 40);
        check_seq("t2_seq", 8'h10, 8);

        // 3: ready toggling 1010...
        do_reset();
        push_words(8'h20, 5);
        enable = 1'b1;
        for (int i = 0; i < 30; i++) begin
            m_ready = ~m_ready;
            step();
        end
        m_ready = 1'b1;
        wait_delivered("t3_count", 5, 20);
        check_seq("t3_seq", 8'h20, 5);

        // 4: drain mid-stream, then resume
        do_reset();
        push_words(8'h30, 8);
        enable  = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 20 && got_q.size() < 3; i++) step();
        enable = 1'b0;
        for (int i = 0; i < 20 && !idle; i++) step();
        chk("t4_idle", 32'(idle), 32'd1);
        chk("t4_conserve", 32'(got_q.size() + fifo_q.size()), 32'd8);
        enable = 1'b1;
        wait_delivered("t4_count", 8, 40);
        check_seq("t4_seq", 8'h30, 8);

        // 4b: enable toggled every cycle
        do_reset();
        push_words(8'h40, 6);
        m_ready = 1'b1;
        for (int i = 0; i < 24; i++) begin
            enable = ~enable;
            step();
        end
        enable = 1'b1;
        wait_delivered("t4b_count", 6, 40);
        check_seq("t4b_seq", 8'h40, 6);

        // 5: async reset with a full buffer discards buffered words
        do_reset();
        push_words(8'h50, 8);
        enable  = 1'b1;
        m_ready = 1'b1;
        repeat (4) step();
        m_ready = 1'b0;
        repeat (6) step();
        @(negedge rd_clk);
        chk("t5_pre_count", 32'(word_count), 32'd1);
        chk("t5_pre_word", 32'(got_q[0]), 32'h50);
        chk("t5_pre_valid", 32'(m_valid), 32'd1);
        @(posedge rd_clk);
        #3;
        rd_rstn = 1'b0;
        model_clear();
        #1;
        chk("t5_rst_valid", 32'(m_valid), 32'd0);
        chk("t5_rst_count", 32'(word_count), 32'd0);
        chk("t5_rst_idle", 32'(idle), 32'd1);
        chk("t5_rst_rd_en", 32'(fifo_rd_en), 32'd0);
        enable = 1'b0;
        repeat (2) step();
        rd_rstn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t5_no_valid", 32'(m_valid), 32'd0);
        end
        got_q.delete();
        enable  = 1'b1;
        m_ready = 1'b1;
        wait_delivered("t5_count", 5, 30);
        check_seq("t5_seq", 8'h53, 5);

        // 6: narrow counter wraps
        do_reset();
        push_words(8'h60, 17);
        enable  = 1'b1;
        m_ready = 1'b1;
        wait_delivered("t6_count", 17, 60);
        @(negedge rd_clk);
        chk("t6_wc4", 32'(wc4), 32'd1);
        chk("t6_wc16", 32'(word_count), 32'd17);
        check_seq("t6_seq", 8'h60, 17);

        enable = 1'b0;
        repeat (4) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
